// File: rtl/mesm6_muldiv.sv
// rtl/mesm6_muldiv.sv - multicycle signed/unsigned multiply/divide unit; optional MESM6_MULDIV_EARLY_EN enables early MUL exit
module mesm6_muldiv #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dvz
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // MUL: running product. DIV: {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg_res;
    logic               neg_rem;

    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic               iter_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Datapath: operand magnitudes, one MUL/DIV step, and sign fix-up of the final result.
    always_comb begin
        is_div    = op_r[1];
        a_neg     = op_r[0] & a_r[WIDTH-1];
        b_neg     = op_r[0] & b_r[WIDTH-1];
        a_mag     = a_neg ? -a_r : a_r;
        b_mag     = b_neg ? -b_r : b_r;

        mul_next  = mplier[0] ? (acc + mcand) : acc;

        // Restoring step: the borrow bit of the trial subtraction is the inverted quotient bit.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, mplier};
        div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     acc[WIDTH-2:0], ~div_trial[WIDTH]};

        iter_last = (cnt == CNT_ONE);
`ifdef MESM6_MULDIV_EARLY_EN
        if (!is_div && ((mplier >> 1) == '0)) begin
            iter_last = 1'b1;
        end
`endif

        prod_fix  = neg_res ? -acc : acc;
        if (!is_div) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dvz) begin
            fix_hi = a_r;
            fix_lo = '1;
        end else begin
            fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    // Control FSM and all architectural state; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dvz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        dvz   <= 1'b0;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= CNT_INIT;
                    mplier  <= b_mag;
                    if (is_div) begin
                        acc   <= {{WIDTH{1'b0}}, a_mag};
                        mcand <= '0;
                    end else begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, a_mag};
                    end
                    if (is_div && (b_r == '0)) begin
                        dvz   <= 1'b1;
                        state <= S_FIX;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CNT_ONE;
                    if (is_div) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (iter_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mesm6_muldiv.sv
// tb/tb_mesm6_muldiv.sv - scoreboard bench for mesm6_muldiv at WIDTH=8 and WIDTH=48
`timescale 1ns/1ps
module tb_mesm6_muldiv;
    localparam logic [1:0] MULU = 2'd0;
    localparam logic [1:0] MULS = 2'd1;
    localparam logic [1:0] DIVU = 2'd2;
    localparam logic [1:0] DIVS = 2'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start8, busy8, done8, dvz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        start48, busy48, done48, dvz48;
    logic [1:0]  op48;
    logic [47:0] a48, b48, hi48, lo48;

    mesm6_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dvz(dvz8)
    );

    mesm6_muldiv #(.WIDTH(48)) dut48 (
        .clk(clk), .reset(reset), .start(start48), .op(op48), .a(a48), .b(b48),
        .busy(busy48), .done(done48), .hi(hi48), .lo(lo48), .dvz(dvz48)
    );

    typedef struct {
        logic [47:0] hi;
        logic [47:0] lo;
        logic        dz;
        int          exp_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q48[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model from native wide arithmetic; lat = edge index after which done is high.
    function automatic void model(input int w, input logic [1:0] op, input logic [47:0] a,
                                  input logic [47:0] b, output exp_t e, output int lat);
        logic signed [127:0] va, vb, p, q, r, bm;
        logic [127:0] mask;
        int bl;
        mask = (128'd1 << w) - 128'd1;
        va = {80'd0, a & mask[47:0]};
        vb = {80'd0, b & mask[47:0]};
        if (op[0] && a[w-1]) va = va - (128'sd1 <<< w);
        if (op[0] && b[w-1]) vb = vb - (128'sd1 <<< w);
        e.dz = 1'b0;
        e.exp_cyc = 0;
        lat = w + 2;
        if (!op[1]) begin
            p = va * vb;
            e.hi = 48'((p >> w) & mask);
            e.lo = 48'(p & mask);
`ifdef MESM6_MULDIV_EARLY_EN
            bm = (vb < 0) ? -vb : vb;
            bl = 0;
            for (int i = 0; i < 128; i++) if (bm[i]) bl = i + 1;
            lat = ((bl < 1) ? 1 : bl) + 2;
`endif
        end else if (vb == 0) begin
            e.dz = 1'b1;
            e.hi = a & mask[47:0];
            e.lo = mask[47:0];
            lat = 2;
        end else begin
            q = va / vb;
            r = va % vb;
            e.hi = 48'(r & mask);
            e.lo = 48'(q & mask);
        end
    endfunction

    task automatic issue(input bit wide, input logic [1:0] op, input logic [47:0] a,
                         input logic [47:0] b, input bit push, input bit wait_edge);
        exp_t e;
        int lat;
        model(wide ? 48 : 8, op, a, b, e, lat);
        if (wait_edge) @(negedge clk);
        e.exp_cyc = cyc + 1 + lat;
        if (wide) begin
            start48 = 1'b1; op48 = op; a48 = a; b48 = b;
            if (push) q48.push_back(e);
        end else begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
            if (push) q8.push_back(e);
        end
        @(negedge clk);
        if (wide) begin
            start48 = 1'b0; op48 = 2'($urandom()); a48 = 48'({$urandom(), $urandom()}); b48 = 48'({$urandom(), $urandom()});
        end else begin
            start8 = 1'b0; op8 = 2'($urandom()); a8 = 8'($urandom()); b8 = 8'($urandom());
        end
    endtask

    task automatic drain(input bit wide);
        int n = 0;
        while (((wide ? q48.size() : q8.size()) != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout w%0d: %0d results outstanding, required 0", wide ? 48 : 8, wide ? q48.size() : q8.size());
            if (wide) q48.delete(); else q8.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard for the 8-bit unit: every done pulse must match the oldest expected result.
    exp_t m8;
    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_spurious_done: done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                m8 = q8.pop_front();
                if (hi8 !== m8.hi[7:0]) begin errors++; $display("FAIL w8_hi: got %h, required %h", hi8, m8.hi[7:0]); end
                checks++;
                if (lo8 !== m8.lo[7:0]) begin errors++; $display("FAIL w8_lo: got %h, required %h", lo8, m8.lo[7:0]); end
                checks++;
                if (dvz8 !== m8.dz) begin errors++; $display("FAIL w8_dvz: got %b, required %b", dvz8, m8.dz); end
                checks++;
                if (cyc !== m8.exp_cyc) begin errors++; $display("FAIL w8_latency: done at cycle %0d, required %0d", cyc, m8.exp_cyc); end
            end
        end
    end

    // Scoreboard for the 48-bit unit.
    exp_t m48;
    always @(negedge clk) begin
        if (done48) begin
            checks++;
            if (q48.size() == 0) begin
                errors++;
                $display("FAIL w48_spurious_done: done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                m48 = q48.pop_front();
                if (hi48 !== m48.hi) begin errors++; $display("FAIL w48_hi: got %h, required %h", hi48, m48.hi); end
                checks++;
                if (lo48 !== m48.lo) begin errors++; $display("FAIL w48_lo: got %h, required %h", lo48, m48.lo); end
                checks++;
                if (dvz48 !== m48.dz) begin errors++; $display("FAIL w48_dvz: got %b, required %b", dvz48, m48.dz); end
                checks++;
                if (cyc !== m48.exp_cyc) begin errors++; $display("FAIL w48_latency: done at cycle %0d, required %0d", cyc, m48.exp_cyc); end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        start48 = 1'b0; op48 = '0; a48 = '0; b48 = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done8); end
        checks++; if ({hi8, lo8} !== 16'h0) begin errors++; $display("FAIL reset_hilo: got %h, required 0000", {hi8, lo8}); end
        checks++; if (dvz8 !== 1'b0) begin errors++; $display("FAIL reset_dvz: got %b, required 0", dvz8); end
        checks++; if ({busy48, done48, dvz48, hi48, lo48} !== 99'd0) begin errors++; $display("FAIL reset_w48: got %h, required 0", {busy48, done48, dvz48, hi48, lo48}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mulu_timing();
        issue(1'b0, MULU, 48'hFF, 48'hFF, 1'b1, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (busy8 !== (k < 10)) begin errors++; $display("FAIL mulu_busy_edge%0d: got %b, required %b", k, busy8, (k < 10)); end
            checks++;
            if (done8 !== (k == 10)) begin errors++; $display("FAIL mulu_done_edge%0d: got %b, required %b", k, done8, (k == 10)); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({hi8, lo8} !== 16'hFE01) begin errors++; $display("FAIL mulu_hold: got %h, required fe01", {hi8, lo8}); end
        drain(1'b0);
    endtask

    task automatic test_signed_ops();
        issue(1'b0, MULS, 48'h80, 48'h80, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, MULS, 48'hFF, 48'h03, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, MULS, 48'h7F, 48'h81, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, DIVS, 48'hF9, 48'h02, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, DIVU, 48'hF9, 48'h02, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, DIVS, 48'h80, 48'hFF, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, DIVS, 48'h07, 48'hFE, 1'b1, 1'b1); drain(1'b0);
    endtask

    task automatic test_div_zero();
        issue(1'b0, DIVU, 48'h2A, 48'h00, 1'b1, 1'b1); drain(1'b0);
        checks++;
        if (dvz8 !== 1'b1) begin errors++; $display("FAIL dvz_held: got %b, required 1", dvz8); end
        issue(1'b0, DIVU, 48'h09, 48'h03, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, DIVS, 48'h85, 48'h00, 1'b1, 1'b1); drain(1'b0);
    endtask

    task automatic test_ignore_start();
        issue(1'b0, MULU, 48'h37, 48'h5A, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        start8 = 1'b1; op8 = DIVU; a8 = 8'h01; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b, required 1", busy8); end
        drain(1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(1'b0, MULS, 48'h7F, 48'h81, 1'b1, 1'b1);
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin errors++; $display("FAIL b2b_wait_done: got no done in %0d cycles, required done", n); end
        issue(1'b0, DIVU, 48'hF9, 48'h02, 1'b1, 1'b0);
        drain(1'b0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(1'b0, MULU, 48'hAB, 48'hCD, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", done8); end
        checks++; if ({hi8, lo8} !== 16'h0) begin errors++; $display("FAIL rstmid_hilo: got %h, required 0000", {hi8, lo8}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done8) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", seen); end
    endtask

    task automatic test_early_exit();
        issue(1'b0, MULU, 48'h11, 48'h05, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, MULU, 48'h5C, 48'h00, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, MULS, 48'h2B, 48'hFF, 1'b1, 1'b1); drain(1'b0);
        issue(1'b0, MULS, 48'h2B, 48'h80, 1'b1, 1'b1); drain(1'b0);
    endtask

    task automatic test_wide();
        issue(1'b1, MULS, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 1'b1); drain(1'b1);
        issue(1'b1, MULU, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1); drain(1'b1);
        issue(1'b1, DIVS, 48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1); drain(1'b1);
        issue(1'b1, DIVU, 48'h1234_5678_9ABC, 48'h0, 1'b1, 1'b1); drain(1'b1);
        issue(1'b1, DIVS, 48'hFFFF_FFFF_FFF9, 48'h2, 1'b1, 1'b1); drain(1'b1);
        for (int i = 0; i < 14; i++) begin
            logic [47:0] ra, rb;
            ra = 48'({$urandom(), $urandom()});
            rb = 48'({$urandom(), $urandom()});
            if (i % 3 == 0) rb = rb >> $urandom_range(47, 20);
            issue(1'b1, 2'(i % 4), ra, rb, 1'b1, 1'b1);
            drain(1'b1);
        end
    endtask

    task automatic test_random_w8();
        for (int i = 0; i < 24; i++) begin
            issue(1'b0, 2'($urandom()), 48'($urandom_range(255, 0)), 48'($urandom_range(255, 0)), 1'b1, 1'b1);
            drain(1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_mulu_timing();
        test_signed_ops();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_early_exit();
        test_random_w8();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
